// File: rtl/lane_stripe_ctrl_pkg.sv
// Shared constants, lane-mode encodings, controller state type and the
// lane-count decode used by the stripe controller and its output registers.
package pcie_lane_pkg;

    localparam int DW     = 8;
    localparam int NLANES = 4;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    // Number of lanes a column spans for a given lane_mode; reserved maps to 4.
    function automatic logic [2:0] lanes_active(input logic [1:0] mode);
        case (mode)
            MODE_X1: lanes_active = 3'd1;
            MODE_X2: lanes_active = 3'd2;
            MODE_X4: lanes_active = 3'd4;
            default: lanes_active = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lane_stripe_ctrl_lane_out_reg.sv
// One lane of the output column: loads a byte and its valid when a column
// commits, and holds both until the downstream signals out_ready.
module lane_out_reg
    import pcie_lane_pkg::*;
(
    input  logic          clk,
    input  logic          reset_L,
    input  logic          load,
    input  logic          out_ready,
    input  logic          lane_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          vout
);

    // Load on commit, otherwise drop the valid once the column is taken.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dout <= '0;
            vout <= 1'b0;
        end else if (load) begin
            vout <= lane_en;
            dout <= lane_en ? din : '0;
        end else if (out_ready) begin
            vout <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_stripe_ctrl.sv
// Round-robin byte striper: collects up to four bytes into a staging column,
// then commits the column to a double-buffered output with per-lane valids.
module lane_stripe_ctrl
    import pcie_lane_pkg::*;
(
    input  logic          clk,
    input  logic          reset_L,
    input  logic [DW-1:0] data_in,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic [1:0]    lane_mode,
    input  logic          flush,
    input  logic          out_ready,
    output logic [DW-1:0] data_out0,
    output logic [DW-1:0] data_out1,
    output logic [DW-1:0] data_out2,
    output logic [DW-1:0] data_out3,
    output logic          valid_out0,
    output logic          valid_out1,
    output logic          valid_out2,
    output logic          valid_out3,
    output logic [1:0]    cur_lane,
    output logic          err_mode
);

    state_t              state;
    logic [DW-1:0]       stage [NLANES];
    logic [NLANES-1:0]   mask;
    logic [2:0]          act_lanes;
    logic                ready_q;

    logic [DW-1:0]       dout [NLANES];
    logic [NLANES-1:0]   vout;

    logic [2:0]          eff_lanes;
    logic                accept;
    logic [DW-1:0]       col_data [NLANES];
    logic [NLANES-1:0]   col_mask;
    logic                wraps;
    logic                out_busy;
    logic                out_free;
    logic                seal;
    logic                commit;
    logic                busy_next;

    assign ready_in = ready_q;

    // Next column contents, seal/commit decisions and output occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        eff_lanes = (state == IDLE) ? lanes_active(lane_mode) : act_lanes;
        accept    = valid_in && ready_q;
        col_data  = stage;
        col_mask  = mask;
        if (state != FULL && accept) begin
            col_data[cur_lane] = data_in;
            col_mask[cur_lane] = 1'b1;
        end
        wraps    = accept && (({1'b0, cur_lane} + 3'd1) == eff_lanes);
        out_busy = |vout;
        out_free = !out_busy || out_ready;
        if (state == FULL) begin
            seal   = 1'b1;
            commit = out_ready;
        end else begin
            seal   = wraps || (flush && |col_mask);
            commit = seal && out_free;
        end
        busy_next = commit || (out_busy && !out_ready);
    end

    // Controller FSM: staging column, fill pointer, mode latch and ready.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            // NOTE: the staging column is only four bytes and must be wiped so a reset mid-column never leaks old data.
            for (int i = 0; i < NLANES; i++) begin
                stage[i] <= '0;
            end
            mask      <= '0;
            cur_lane  <= 2'd0;
            act_lanes <= 3'd4;
            err_mode  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
            if (state == IDLE) begin
                act_lanes <= eff_lanes;
                if (lane_mode == 2'd3) begin
                    err_mode <= 1'b1;
                end
            end
            if (commit) begin
                for (int i = 0; i < NLANES; i++) begin
                    stage[i] <= '0;
                end
                mask     <= '0;
                cur_lane <= 2'd0;
                state    <= FILL;
                ready_q  <= 1'b1;
            end else if (seal) begin
                stage    <= col_data;
                mask     <= col_mask;
                cur_lane <= 2'd0;
                state    <= FULL;
                ready_q  <= 1'b0;
            end else begin
                stage <= col_data;
                mask  <= col_mask;
                if (accept) begin
                    cur_lane <= cur_lane + 2'd1;
                end
                state   <= (|col_mask || busy_next) ? FILL : IDLE;
                ready_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        lane_out_reg u_out (
            .clk       (clk),
            .reset_L   (reset_L),
            .load      (commit),
            .out_ready (out_ready),
            .lane_en   (col_mask[i]),
            .din       (col_data[i]),
            .dout      (dout[i]),
            .vout      (vout[i])
        );
    end

    assign data_out0  = dout[0];
    assign data_out1  = dout[1];
    assign data_out2  = dout[2];
    assign data_out3  = dout[3];
    assign valid_out0 = vout[0];
    assign valid_out1 = vout[1];
    assign valid_out2 = vout[2];
    assign valid_out3 = vout[3];

endmodule
